semaforo_multifase: RTL

//  Parametrised N-approach traffic-light controller, next generation of the 2-way fsm_semaforo.

---
 rtl/semaforo_pkg.sv | 19 +
 rtl/semaforo_rr_sel.sv | 36 +++
 rtl/semaforo_multifase.sv | 138 +++++++++++++
 3 files changed

// File: rtl/semaforo_pkg.sv
// Shared types and helpers for the multi-approach traffic-light controller.
// Phase encoding and one-hot lamp decode used by the FSM and the selector.
package semaforo_pkg;

  typedef enum logic [1:0] {
    GREEN,
    YELLOW,
    ALLRED,
    EMERG_GREEN
  } phase_t;

  localparam int MAX_DIRS = 32;

  function automatic logic [MAX_DIRS-1:0] onehot(input logic [4:0] idx);
    onehot = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/semaforo_rr_sel.sv
// Round-robin picker: first approach with demand after active_dir,
// wrapping modulo NUM_DIRS; also flags demand on any other approach.
module semaforo_rr_sel
  import semaforo_pkg::*;
#(
  parameter int NUM_DIRS = 4,
  parameter int DIR_W    = 2
) (
  input  logic [NUM_DIRS-1:0] sensor,
  input  logic [DIR_W-1:0]    active_dir,
  output logic [DIR_W-1:0]    next_dir,
  output logic                any_other
);

  logic [NUM_DIRS-1:0] self_oh;
  logic                found;
  int                  idx;

  assign self_oh   = NUM_DIRS'(onehot(5'(active_dir)));
  assign any_other = |(sensor & ~self_oh);

  // Scan upward from active_dir+1; keep active_dir if nobody else waits.
  always_comb begin
    next_dir = active_dir;
    found    = 1'b0;
    idx      = 0;
    for (int i = 1; i < NUM_DIRS; i++) begin
      idx = (int'(active_dir) + i) % NUM_DIRS;
      if (!found && sensor[idx]) begin
        found    = 1'b1;
        next_dir = DIR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/semaforo_multifase.sv
// N-approach traffic-light controller: timed green/yellow/all-red phases,
// round-robin demand service and emergency preemption.
module semaforo_multifase
  import semaforo_pkg::*;
#(
  parameter int NUM_DIRS    = 4,
  parameter int CNT_W       = 8,
  parameter int T_GREEN_MIN = 10,
  parameter int T_GREEN_MAX = 30,
  parameter int T_YELLOW    = 3,
  parameter int T_ALLRED    = 1,
  localparam int DIR_W = (NUM_DIRS > 2) ? $clog2(NUM_DIRS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic [NUM_DIRS-1:0] sensor,
  input  logic                emerg,
  input  logic [DIR_W-1:0]    emerg_dir,
  output logic [NUM_DIRS-1:0] verde,
  output logic [NUM_DIRS-1:0] amarillo,
  output logic [NUM_DIRS-1:0] rojo,
  output logic [DIR_W-1:0]    active_dir,
  output logic                emerg_active
);

  localparam logic [CNT_W:0]   E_GMIN = (CNT_W+1)'(T_GREEN_MIN);
  localparam logic [CNT_W:0]   E_GMAX = (CNT_W+1)'(T_GREEN_MAX);
  localparam logic [CNT_W:0]   E_YEL  = (CNT_W+1)'(T_YELLOW);
  localparam logic [CNT_W:0]   E_AR   = (CNT_W+1)'(T_ALLRED);
  localparam logic [CNT_W-1:0] T_SAT  = CNT_W'(T_GREEN_MAX);

  phase_t              phase_q, phase_d;
  logic [CNT_W-1:0]    timer_q, timer_d;
  logic [DIR_W-1:0]    dir_q, dir_d;
  logic [DIR_W-1:0]    next_q, next_d;

  logic [NUM_DIRS-1:0] self_oh;
  logic [CNT_W:0]      elapsed;
  logic [CNT_W-1:0]    timer_inc;
  logic [DIR_W-1:0]    ed;
  logic [DIR_W-1:0]    rr_next;
  logic                other_dem;
  logic                own_dem;

  semaforo_rr_sel #(
    .NUM_DIRS (NUM_DIRS),
    .DIR_W    (DIR_W)
  ) u_rr (
    .sensor     (sensor),
    .active_dir (dir_q),
    .next_dir   (rr_next),
    .any_other  (other_dem)
  );

  assign self_oh   = NUM_DIRS'(onehot(5'(dir_q)));
  assign own_dem   = |(sensor & self_oh);
  assign elapsed   = {1'b0, timer_q} + 1'b1;
  assign timer_inc = (timer_q >= T_SAT) ? timer_q : timer_q + 1'b1;
  assign ed        = (32'(emerg_dir) < NUM_DIRS) ? emerg_dir : '0;

  // Phase state, timer and direction registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q <= GREEN;
      timer_q <= '0;
      dir_q   <= '0;
      next_q  <= '0;
    end else begin
      phase_q <= phase_d;
      timer_q <= timer_d;
      dir_q   <= dir_d;
      next_q  <= next_d;
    end
  end

  // Next phase: timed moves on tick, preemption entry/exit on any clk.
  always_comb begin
    phase_d = phase_q;
    timer_d = timer_q;
    dir_d   = dir_q;
    next_d  = next_q;
    if (tick) timer_d = timer_inc;
    unique case (phase_q)
      GREEN: begin
        if (emerg && dir_q == ed) begin
          phase_d = EMERG_GREEN;
          timer_d = '0;
        end else if (emerg) begin
          phase_d = YELLOW;
          timer_d = '0;
          next_d  = ed;
        end else if (tick && other_dem &&
                     ((elapsed >= E_GMIN && !own_dem) ||
                      elapsed >= E_GMAX)) begin
          phase_d = YELLOW;
          timer_d = '0;
          next_d  = rr_next;
        end
      end
      YELLOW: begin
        if (emerg) next_d = ed;
        if (tick && elapsed >= E_YEL) begin
          phase_d = ALLRED;
          timer_d = '0;
        end
      end
      ALLRED: begin
        if (emerg) next_d = ed;
        if (tick && elapsed >= E_AR) begin
          phase_d = emerg ? EMERG_GREEN : GREEN;
          timer_d = '0;
          dir_d   = emerg ? ed : next_q;
        end
      end
      EMERG_GREEN: begin
        if (!emerg) begin
          phase_d = GREEN;
          timer_d = '0;
        end
      end
      default: ;
    endcase
  end

  // Moore lamp decode from registered state only.
  always_comb begin
    verde    = '0;
    amarillo = '0;
    if (phase_q == GREEN || phase_q == EMERG_GREEN) verde = self_oh;
    if (phase_q == YELLOW) amarillo = self_oh;
    rojo = ~(verde | amarillo);
  end

  assign active_dir   = dir_q;
  assign emerg_active = (phase_q == EMERG_GREEN);

endmodule
